// File: rtl/if_stage_if.sv
// if_stage_if -- bundle of the fetch-stage signals between the next-PC logic,
// hazard unit, instruction memory and the IF/ID consumer on one side and
// if_stage on the other.
//   npc, redirect, stall     : next-PC / hazard controls into the fetch stage
//   imem_rvalid, imem_rdata  : instruction memory response
//   pc_out, imem_req/addr    : current PC and the fetch request
//   if_id_pc/instr/valid     : IF/ID pipeline register contents
//   fetch_state              : fetch FSM state (IDLE=0 FETCH=1 DROP=2 BUF=3)
// slave  : seen by if_stage
// master : seen by the surrounding pipeline / memory
interface if_stage_if;
    logic [31:0] npc;
    logic        redirect;
    logic        stall;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [1:0]  fetch_state;

    modport slave (
        input  npc, redirect, stall, imem_rvalid, imem_rdata,
        output pc_out, imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_state
    );
    modport master (
        output npc, redirect, stall, imem_rvalid, imem_rdata,
        input  pc_out, imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_state
    );
endinterface

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with a single outstanding imem request.
// Holds the fetch PC, issues requests in FETCH, drops responses made stale by
// a redirect (DROP), parks a response that arrived during a stall (BUF), and
// owns the IF/ID pipeline register.
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : if_stage_if.slave (npc/redirect/stall/imem response in,
//          pc_out/imem request/IF/ID/fetch_state out)
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    if_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2,
        S_BUF   = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_tgt, w_tgt_nxt;
    logic [31:0] r_buf, w_buf_nxt;
    logic [31:0] r_if_pc, w_if_pc_nxt;
    logic [31:0] r_if_instr, w_if_instr_nxt;
    logic        r_if_valid, w_if_valid_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_tgt      <= 32'd0;
            r_buf      <= 32'd0;
            r_if_pc    <= 32'd0;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_tgt      <= w_tgt_nxt;
            r_buf      <= w_buf_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_tgt_nxt      = r_tgt;
        w_buf_nxt      = r_buf;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = r_if_instr;
        w_if_valid_nxt = r_if_valid;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (bus.redirect) begin
                    // Squash the IF/ID slot; the in-flight word is wrong-path.
                    w_if_valid_nxt = 1'b0;
                    w_if_instr_nxt = NOP_INSTR;
                    if (bus.imem_rvalid) begin
                        w_pc_nxt = bus.npc;
                    end else begin
                        // Response still owed: remember the target and eat it later.
                        w_tgt_nxt   = bus.npc;
                        w_state_nxt = S_DROP;
                    end
                end else if (bus.imem_rvalid) begin
                    if (!bus.stall) begin
                        w_if_pc_nxt    = r_pc;
                        w_if_instr_nxt = bus.imem_rdata;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = bus.npc;
                    end else begin
                        w_buf_nxt   = bus.imem_rdata;
                        w_state_nxt = S_BUF;
                    end
                end else if (!bus.stall) begin
                    // Downstream consumed IF/ID but nothing new arrived: bubble.
                    w_if_valid_nxt = 1'b0;
                    w_if_instr_nxt = NOP_INSTR;
                end
            end
            S_DROP: begin
                if (bus.imem_rvalid) begin
                    w_pc_nxt    = bus.redirect ? bus.npc : r_tgt;
                    w_state_nxt = S_FETCH;
                end else if (bus.redirect) begin
                    w_tgt_nxt = bus.npc;
                end
            end
            S_BUF: begin
                if (bus.redirect) begin
                    w_pc_nxt       = bus.npc;
                    w_if_valid_nxt = 1'b0;
                    w_if_instr_nxt = NOP_INSTR;
                    w_state_nxt    = S_FETCH;
                end else if (!bus.stall) begin
                    w_if_pc_nxt    = r_pc;
                    w_if_instr_nxt = r_buf;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = bus.npc;
                    w_state_nxt    = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.pc_out      = r_pc;
    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.if_id_pc    = r_if_pc;
    assign bus.if_id_instr = r_if_instr;
    assign bus.if_id_valid = r_if_valid;
    assign bus.fetch_state = r_state;
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    logic clk;
    logic rstn;
    int   n_chk;
    int   n_pass;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    task automatic drv(input logic rv, input logic [31:0] rd, input logic st,
                       input logic rdir, input logic [31:0] np);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        bus.stall       = st;
        bus.redirect    = rdir;
        bus.npc         = np;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins, input logic v);
        chk({tag, ".pc"},    bus.if_id_pc, pc);
        chk({tag, ".instr"}, bus.if_id_instr, ins);
        chk({tag, ".valid"}, 32'(bus.if_id_valid), 32'(v));
    endtask

    task automatic chk_fe(input string tag, input logic [1:0] st,
                          input logic req, input logic [31:0] addr);
        chk({tag, ".state"}, 32'(bus.fetch_state), 32'(st));
        chk({tag, ".req"},   32'(bus.imem_req), 32'(req));
        chk({tag, ".addr"},  bus.imem_addr, addr);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rstn   = 1'b0;
        drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd4);
        tick();
        tick();
        chk_fe("rst", 2'd0, 1'b0, 32'h0);
        chk("rst.pc_out", bus.pc_out, 32'h0);
        chk_ifid("rst", 32'h0, 32'h13, 1'b0);

        // Reset release: IDLE then FETCH to 0x0
        rstn = 1'b1;
        tick();
        chk_fe("rel", 2'd1, 1'b1, 32'h0);
        drv(1'b1, mdat(32'h0), 1'b0, 1'b0, 32'h4);
        tick();
        chk_ifid("f0", 32'h0, 32'hA5A5_0000, 1'b1);
        chk_fe("f0", 2'd1, 1'b1, 32'h4);
        drv(1'b0, 32'd0, 1'b0, 1'b0, 32'h8);
        tick();
        chk("bubble.valid", 32'(bus.if_id_valid), 32'd0);
        chk("bubble.instr", bus.if_id_instr, 32'h13);
        drv(1'b1, mdat(32'h4), 1'b0, 1'b0, 32'h8);
        tick();
        chk_ifid("f4", 32'h4, 32'hA5A5_0004, 1'b1);
        chk_fe("f4", 2'd1, 1'b1, 32'h8);

        // Stall with request pending, then response under stall -> BUF
        drv(1'b0, 32'd0, 1'b1, 1'b0, 32'hC);
        tick();
        chk_ifid("stl", 32'h4, 32'hA5A5_0004, 1'b1);
        drv(1'b1, mdat(32'h8), 1'b1, 1'b0, 32'hC);
        tick();
        chk_fe("buf", 2'd3, 1'b0, 32'h8);
        chk_ifid("buf", 32'h4, 32'hA5A5_0004, 1'b1);
        drv(1'b0, 32'd0, 1'b1, 1'b0, 32'hC);
        tick();
        chk_fe("bufhold", 2'd3, 1'b0, 32'h8);
        drv(1'b0, 32'd0, 1'b0, 1'b0, 32'hC);
        tick();
        chk_ifid("bufrel", 32'h8, 32'hA5A5_0008, 1'b1);
        chk_fe("bufrel", 2'd1, 1'b1, 32'hC);

        // Redirect to 0x100 with 0xC outstanding -> DROP, late data discarded
        drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h100);
        tick();
        chk_fe("drop", 2'd2, 1'b0, 32'hC);
        chk_ifid("drop", 32'h8, 32'h13, 1'b0);
        drv(1'b1, mdat(32'hC), 1'b0, 1'b0, 32'h10);
        tick();
        chk_fe("drop2f", 2'd1, 1'b1, 32'h100);
        chk_ifid("drop2f", 32'h8, 32'h13, 1'b0);
        drv(1'b1, mdat(32'h100), 1'b0, 1'b0, 32'h104);
        tick();
        chk_ifid("f100", 32'h100, 32'hA5A5_0100, 1'b1);

        // Redirect to 0x200 coinciding with rvalid in FETCH
        drv(1'b1, mdat(32'h104), 1'b0, 1'b1, 32'h200);
        tick();
        chk_fe("rdrv", 2'd1, 1'b1, 32'h200);
        chk_ifid("rdrv", 32'h100, 32'h13, 1'b0);

        // Two redirects while dropping: latest target (0x300) wins
        drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h100);
        tick();
        drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h300);
        tick();
        chk_fe("drop2", 2'd2, 1'b0, 32'h200);
        drv(1'b1, mdat(32'h200), 1'b0, 1'b0, 32'h204);
        tick();
        chk_fe("tgt300", 2'd1, 1'b1, 32'h300);

        // Fill IF/ID, park a word in BUF, then redirect+stall discards it
        drv(1'b1, mdat(32'h300), 1'b0, 1'b0, 32'h304);
        tick();
        chk_ifid("f300", 32'h300, 32'hA5A5_0300, 1'b1);
        drv(1'b0, 32'd0, 1'b1, 1'b0, 32'h308);
        tick();
        drv(1'b1, mdat(32'h304), 1'b1, 1'b0, 32'h308);
        tick();
        chk_fe("buf2", 2'd3, 1'b0, 32'h304);
        drv(1'b0, 32'd0, 1'b1, 1'b1, 32'h400);
        tick();
        chk_fe("bufrd", 2'd1, 1'b1, 32'h400);
        chk_ifid("bufrd", 32'h300, 32'h13, 1'b0);

        // Reset in the middle of DROP
        drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h500);
        tick();
        chk_fe("drop3", 2'd2, 1'b0, 32'h400);
        rstn = 1'b0;
        drv(1'b0, 32'd0, 1'b0, 1'b0, 32'h4);
        tick();
        chk("mrst.pc_out", bus.pc_out, 32'h0);
        chk_fe("mrst", 2'd0, 1'b0, 32'h0);
        chk_ifid("mrst", 32'h0, 32'h13, 1'b0);
        rstn = 1'b1;
        tick();
        chk_fe("mrel", 2'd1, 1'b1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, instruction word placed in IF/ID when it holds a bubble.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 npc  in  32  next PC from next-PC logic: PC+4, or the redirect target when redirect=1.
REQ-006 redirect  in  1  taken branch/jump/jalr resolved in EX; npc carries the target.
REQ-007 stall  in  1  hold request from the hazard unit; freezes IF/ID and PC advance.
REQ-008 imem_rvalid  in  1  instruction memory returns data for the outstanding request.
REQ-009 imem_rdata  in  32  instruction word, valid when imem_rvalid=1.
REQ-010 pc_out  out  32  current fetch PC, drives the next-PC logic PC input.
REQ-011 imem_req  out  1  fetch request, held high until imem_rvalid.
REQ-012 imem_addr  out  32  fetch address, equals pc_out.
REQ-013 if_id_pc  out  32  IF/ID pipeline register: PC of the held instruction.
REQ-014 if_id_instr  out  32  IF/ID pipeline register: instruction word.
REQ-015 if_id_valid  out  1  IF/ID holds a real instruction.
REQ-016 fetch_state  out  2  FSM state: IDLE=0, FETCH=1, DROP=2, BUF=3.

Function
REQ-017 At most one imem request is outstanding; imem_req=1 only in FETCH.
REQ-018 IDLE: no request; next state is FETCH unconditionally.
REQ-019 FETCH, redirect=1 and rvalid=1: discard rdata; pc<=npc; if_id_valid<=0; stay in FETCH.
REQ-020 FETCH, redirect=1 and rvalid=0: tgt<=npc; if_id_valid<=0; go to DROP.
REQ-021 FETCH, rvalid=1, stall=0: IF/ID<={pc, rdata, 1}; pc<=npc; stay in FETCH.
REQ-022 FETCH, rvalid=1, stall=1: buf<=rdata; pc holds; IF/ID holds; go to BUF.
REQ-023 FETCH, rvalid=0: if stall=0, if_id_valid<=0 (bubble); if stall=1, IF/ID holds.
REQ-024 DROP: imem_req=0. On rvalid, discard the data: pc<=tgt, or pc<=npc if redirect is also 1; go to FETCH.
REQ-025 DROP with redirect and no rvalid: tgt<=npc (latest redirect wins).
REQ-026 BUF: imem_req=0. redirect=1: discard buf; pc<=npc; if_id_valid<=0; go to FETCH.
REQ-027 BUF: stall=0 and redirect=0: IF/ID<={pc, buf, 1}; pc<=npc; go to FETCH. stall=1: hold all.
REQ-028 redirect takes priority over stall in every state.
REQ-029 Whenever if_id_valid is cleared, if_id_instr<=NOP_INSTR and if_id_pc holds its value.
REQ-030 PC arithmetic is external; the block never adds to pc internally; 32-bit values pass through unmodified.

Reset
REQ-031 rstn=0 at a clock edge: pc<=RESET_PC, state<=IDLE, imem_req=0, if_id_valid<=0, if_id_pc<=0, if_id_instr<=NOP_INSTR, tgt<=0, buf<=0.
REQ-032 Reset asserted with a request outstanding abandons that request; the bench does not return a late rvalid after reset.
REQ-033 First request after reset release is issued in the second cycle (IDLE, then FETCH).

Verification
REQ-034 Reset release, npc=pc+4, rvalid one cycle after each req, rdata=addr^32'hA5A5_0000 -> imem_addr 0x0, 0x4, 0x8; IF/ID shows (0x0, 0xA5A5_0000, 1) and so on; fetch_state 0->1.
REQ-035 stall=1 while FETCH receives rvalid at pc=0x8 -> state BUF, imem_req=0, IF/ID holds the 0x4 entry; stall drops -> IF/ID=(0x8, data, 1), next imem_addr=0xC.
REQ-036 redirect=1 with npc=0x100 while a request to 0xC is pending (rvalid=0) -> DROP, if_id_valid=0; late rvalid data discarded; next imem_addr=0x100.
REQ-037 redirect=1 with npc=0x200 in the same cycle as rvalid in FETCH -> data discarded, if_id_valid=0, next imem_addr=0x200, state stays FETCH.
REQ-038 Second redirect in DROP (npc=0x300 after 0x100) -> next fetch address 0x300; redirect together with stall=1 in BUF -> buf discarded, if_id_valid=0.
REQ-039 rstn=0 mid-DROP -> the next cycle shows pc_out=RESET_PC, fetch_state=0, if_id_instr=0x0000_0013, if_id_valid=0.
